// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length decoder.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    EXPAND,
    WR,
    FLUSH,
    FINISH
  } rle_state_e;

  // Bit offsets of the two (count, value) pairs inside one compressed word.
  localparam int CNT0_LSB = 0;
  localparam int VAL0_LSB = 8;
  localparam int CNT1_LSB = 16;
  localparam int VAL1_LSB = 24;

  localparam int MAX_MSG_BYTES_DEFAULT = 262144;

endpackage

// File: rtl/rle_decode_if.sv
// Single-port dpsram bus: the decoder is master, the memory is slave.
// Read data is valid the cycle after the address; port_A_we = 1 marks a write.
interface rle_decode_if #(
  parameter int ADDR_W = 16
);

  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;
  logic              port_A_we;

  modport master (
    output port_A_clk,
    output port_A_addr,
    output port_A_data_in,
    output port_A_we,
    input  port_A_data_out
  );

  modport slave (
    input  port_A_clk,
    input  port_A_addr,
    input  port_A_data_in,
    input  port_A_we,
    output port_A_data_out
  );

endinterface

// File: rtl/rle_pack_buf.sv
// Byte-to-word packer: first pushed byte lands in [7:0]; unused upper bytes stay zero.
module rle_pack_buf (
  input  logic        clk,
  input  logic        nreset,
  input  logic        push,
  input  logic        clear,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full,
  output logic        partial
);

  logic [2:0] fill;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fill <= 3'd0;
      word <= 32'd0;
    end else if (clear) begin
      fill <= 3'd0;
      word <= 32'd0;
    end else if (push) begin
      word <= word | ({24'd0, din} << {fill[1:0], 3'b000});
      fill <= fill + 3'd1;
    end
  end

  assign full    = (fill == 3'd4);
  assign partial = (fill != 3'd0) && !full;

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads (count, value) pairs from dpsram and writes the expanded bytes back.
// Define RLE_DECODE_CHECK_EN to flag zero counts and oversize output through the error output.
module rle_decode
  import rle_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [31:0]  rle_addr,
  input  logic [31:0]  rle_size,
  input  logic [31:0]  message_addr,
  output logic [31:0]  message_size,
  output logic         done,
  output logic         error,
  output rle_state_e   state,
  rle_decode_if.master mem
);

  logic [31:0]       rle_base;
  logic [31:0]       msg_base;
  logic [31:0]       total_pairs;
  logic [31:0]       pair_cnt;
  logic [31:0]       rd_idx;
  logic [31:0]       out_idx;
  logic [7:0]        cnt;
  logic [7:0]        val;
  logic [7:0]        p1_cnt;
  logic [7:0]        p1_val;
  logic              lane;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  logic [31:0] buf_word;
  logic        buf_full;
  logic        buf_partial;
  logic        push;
  logic        clear;
  logic        can_emit;
  logic        limit_hit;

  assign mem.port_A_clk = clk;
  assign rd_addr = ADDR_W'(rle_base + rd_idx);
  assign wr_addr = ADDR_W'(msg_base + out_idx);

  always_comb begin
    can_emit = (cnt != 8'd0) && !buf_full;
`ifdef RLE_DECODE_CHECK_EN
    limit_hit = can_emit && (message_size >= 32'(MAX_MSG_BYTES));
`else
    limit_hit = 1'b0;
`endif
    push  = (state == EXPAND) && can_emit && !limit_hit;
    clear = ((state == IDLE) && start) || ((state == EXPAND) && buf_full) ||
            (state == FLUSH);
  end

  rle_pack_buf u_pack (
    .clk     (clk),
    .nreset  (nreset),
    .push    (push),
    .clear   (clear),
    .din     (val),
    .word    (buf_word),
    .full    (buf_full),
    .partial (buf_partial)
  );

`ifndef RLE_DECODE_CHECK_EN
  assign error = 1'b0;
`endif

  // Bus outputs are registered, so they are loaded on the transition into
  // RD_REQ / WR / FLUSH and are therefore visible during that state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state              <= IDLE;
      message_size       <= 32'd0;
      done               <= 1'b0;
      mem.port_A_we      <= 1'b0;
      mem.port_A_addr    <= '0;
      mem.port_A_data_in <= 32'd0;
      rle_base           <= 32'd0;
      msg_base           <= 32'd0;
      total_pairs        <= 32'd0;
      pair_cnt           <= 32'd0;
      rd_idx             <= 32'd0;
      out_idx            <= 32'd0;
      cnt                <= 8'd0;
      val                <= 8'd0;
      p1_cnt             <= 8'd0;
      p1_val             <= 8'd0;
      lane               <= 1'b0;
`ifdef RLE_DECODE_CHECK_EN
      error              <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rle_base     <= rle_addr;
            msg_base     <= message_addr;
            total_pairs  <= rle_size >> 1;
            pair_cnt     <= 32'd0;
            rd_idx       <= 32'd0;
            out_idx      <= 32'd0;
            message_size <= 32'd0;
            cnt          <= 8'd0;
            lane         <= 1'b0;
`ifdef RLE_DECODE_CHECK_EN
            error        <= 1'b0;
`endif
            if ((rle_size >> 1) == 32'd0) begin
              state <= FINISH;
            end else begin
              state           <= RD_REQ;
              mem.port_A_addr <= ADDR_W'(rle_addr);
            end
          end
        end

        RD_REQ: state <= RD_WAIT;

        RD_WAIT: begin
          rd_idx <= rd_idx + 32'd1;
          lane   <= 1'b0;
          cnt    <= mem.port_A_data_out[CNT0_LSB +: 8];
          val    <= mem.port_A_data_out[VAL0_LSB +: 8];
          p1_cnt <= mem.port_A_data_out[CNT1_LSB +: 8];
          p1_val <= mem.port_A_data_out[VAL1_LSB +: 8];
          state  <= EXPAND;
`ifdef RLE_DECODE_CHECK_EN
          if (mem.port_A_data_out[CNT0_LSB +: 8] == 8'd0) begin
            error <= 1'b1;
            if (buf_partial) begin
              state              <= FLUSH;
              mem.port_A_we      <= 1'b1;
              mem.port_A_addr    <= wr_addr;
              mem.port_A_data_in <= buf_word;
            end else begin
              state <= FINISH;
            end
          end
`endif
        end

        EXPAND: begin
          if (buf_full) begin
            state              <= WR;
            mem.port_A_we      <= 1'b1;
            mem.port_A_addr    <= wr_addr;
            mem.port_A_data_in <= buf_word;
            out_idx            <= out_idx + 32'd1;
          end else if (limit_hit) begin
`ifdef RLE_DECODE_CHECK_EN
            error <= 1'b1;
`endif
            if (buf_partial) begin
              state              <= FLUSH;
              mem.port_A_we      <= 1'b1;
              mem.port_A_addr    <= wr_addr;
              mem.port_A_data_in <= buf_word;
            end else begin
              state <= FINISH;
            end
          end else if (cnt != 8'd0) begin
            cnt          <= cnt - 8'd1;
            message_size <= message_size + 32'd1;
          end else if (pair_cnt + 32'd1 == total_pairs) begin
            pair_cnt <= pair_cnt + 32'd1;
            if (buf_partial) begin
              state              <= FLUSH;
              mem.port_A_we      <= 1'b1;
              mem.port_A_addr    <= wr_addr;
              mem.port_A_data_in <= buf_word;
            end else begin
              state <= FINISH;
            end
          end else if (!lane) begin
            pair_cnt <= pair_cnt + 32'd1;
            lane     <= 1'b1;
            cnt      <= p1_cnt;
            val      <= p1_val;
`ifdef RLE_DECODE_CHECK_EN
            if (p1_cnt == 8'd0) begin
              error <= 1'b1;
              if (buf_partial) begin
                state              <= FLUSH;
                mem.port_A_we      <= 1'b1;
                mem.port_A_addr    <= wr_addr;
                mem.port_A_data_in <= buf_word;
              end else begin
                state <= FINISH;
              end
            end
`endif
          end else begin
            pair_cnt        <= pair_cnt + 32'd1;
            state           <= RD_REQ;
            mem.port_A_addr <= rd_addr;
          end
        end

        WR: begin
          mem.port_A_we <= 1'b0;
          state         <= EXPAND;
        end

        FLUSH: begin
          mem.port_A_we <= 1'b0;
          state         <= FINISH;
        end

        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decode.sv
// Randomized scoreboard bench for rle_decode against a byte-list reference model.
`timescale 1ns/1ps
module tb_rle_decode;
  import rle_pkg::*;

  localparam int ADDR_W       = 16;
  localparam int EW           = ADDR_W + 32;
  localparam int MAX_BYTES    = 1000;
  localparam int CYCLE_BUDGET = 20000;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rle_addr = 32'd0;
  logic [31:0] rle_size = 32'd0;
  logic [31:0] message_addr = 32'd0;
  logic [31:0] message_size;
  logic        done;
  logic        error;
  rle_state_e  state;

  rle_decode_if #(.ADDR_W(ADDR_W)) mem_if ();

  rle_decode #(.ADDR_W(ADDR_W), .MAX_MSG_BYTES(MAX_BYTES)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .start        (start),
    .rle_addr     (rle_addr),
    .rle_size     (rle_size),
    .message_addr (message_addr),
    .message_size (message_size),
    .done         (done),
    .error        (error),
    .state        (state),
    .mem          (mem_if.master)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = 32'd0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_if.port_A_we) ram[mem_if.port_A_addr] <= mem_if.port_A_data_in;
    mem_if.port_A_data_out <= ram[mem_if.port_A_addr];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [32:0]   exp_done_q[$];
  logic [7:0]    src[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            done_seen = 0;
  int            done_mark = 0;
  logic [31:0]   exp_size_last = 32'd0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (nreset) begin
      if (mem_if.port_A_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                   mem_if.port_A_addr, mem_if.port_A_data_in);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", 64'(mem_if.port_A_addr), 64'(e[EW-1:32]));
          check("write_data", 64'(mem_if.port_A_data_in), 64'(e[31:0]));
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: size %0d error %0b, no done expected", message_size, error);
        end else begin
          logic [32:0] d;
          d = exp_done_q.pop_front();
          check("done_size", 64'(message_size), 64'(d[31:0]));
          check("done_error", 64'(error), 64'(d[32]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] base, input int nbytes);
    int nwords;
    nwords = (nbytes + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word;
      word = $urandom;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < nbytes) word[8*b +: 8] = src[w*4+b];
      pre_addr = ADDR_W'(base + 32'(w));
      pre_data = word;
      pre_we   = 1'b1;
      tick(1);
    end
    pre_we = 1'b0;
  endtask

  // Reference: expand pairs into a byte list, then cut the list into little-endian words.
  task automatic model(input logic [31:0] m_addr, input int nbytes);
    logic [7:0] out_b[$];
    logic       err;
    err = 1'b0;
    for (int p = 0; p < nbytes / 2 && !err; p++) begin
      int         c;
      logic [7:0] v;
      c = int'(src[2*p]);
      v = src[2*p+1];
`ifdef RLE_DECODE_CHECK_EN
      if (c == 0) err = 1'b1;
`endif
      for (int k = 0; k < c && !err; k++) begin
`ifdef RLE_DECODE_CHECK_EN
        if (out_b.size() == MAX_BYTES) begin
          err = 1'b1;
          break;
        end
`endif
        out_b.push_back(v);
      end
    end
    for (int w = 0; w * 4 < out_b.size(); w++) begin
      logic [31:0]       word;
      logic [ADDR_W-1:0] a;
      word = 32'd0;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < out_b.size()) word[8*b +: 8] = out_b[w*4+b];
      a = ADDR_W'(m_addr + 32'(w));
      exp_q.push_back({a, word});
    end
    exp_size_last = 32'(out_b.size());
    exp_done_q.push_back({err, exp_size_last});
  endtask

  task automatic start_frame(input logic [31:0] r_addr, input logic [31:0] m_addr, input int nbytes);
    preload(r_addr, nbytes);
    model(m_addr, nbytes);
    rle_addr     = r_addr;
    rle_size     = 32'(nbytes);
    message_addr = m_addr;
    done_mark    = done_seen;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string name);
    int cyc;
    cyc = 0;
    while (done_seen == done_mark && cyc < CYCLE_BUDGET) begin
      tick(1);
      cyc++;
    end
    if (done_seen == done_mark) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, CYCLE_BUDGET);
    end
    tick(3);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_size_hold"}, 64'(message_size), 64'(exp_size_last));
    exp_q.delete();
    exp_done_q.delete();
  endtask

  task automatic random_src(input int nbytes);
    src.delete();
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 0)
        src.push_back(($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 20)));
      else
        src.push_back(8'($urandom));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tick(2);
    check("reset_size", 64'(message_size), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_we", 64'(mem_if.port_A_we), 64'd0);
    check("reset_addr", 64'(mem_if.port_A_addr), 64'd0);
    check("reset_wdata", 64'(mem_if.port_A_data_in), 64'd0);
    check("reset_state", 64'(state), 64'(IDLE));
    nreset = 1'b1;
    tick(2);

    // two pairs in one word
    src = '{8'h03, 8'h41, 8'h02, 8'h42};
    start_frame(32'h0000_0100, 32'h0000_2000, 4);
    finish_frame("two_pairs");

    // one pair of 255 bytes
    src = '{8'hFF, 8'h55};
    start_frame(32'h0000_0100, 32'h0000_3000, 2);
    finish_frame("long_run");

    // empty frame: done two edges after start
    src.delete();
    start_frame(32'h0000_0100, 32'h0000_3800, 0);
    check("empty_state", 64'(state), 64'(FINISH));
    tick(1);
    check("empty_done_latency", 64'(done), 64'd1);
    finish_frame("empty");

    // zero-count pair, alone and mid-frame; odd trailing byte
    src = '{8'h00, 8'h11};
    start_frame(32'h0000_0100, 32'h0000_3900, 2);
    finish_frame("zero_pair");
    src = '{8'h03, 8'hAA, 8'h00, 8'h11, 8'h02, 8'hBB, 8'h07};
    start_frame(32'h0000_0100, 32'h0000_3A00, 7);
    finish_frame("zero_mid_odd");

    // output beyond the size limit (reported only when checks are built in)
    src.delete();
    for (int i = 0; i < 8; i++) begin
      src.push_back(8'hFF);
      src.push_back(8'(8'h60 + i));
    end
    start_frame(32'h0000_0100, 32'h0000_4000, 16);
    finish_frame("big");

    // message address wraps around the dpsram
    random_src(20);
    start_frame(32'h1234_0100, 32'hABCD_FFF8, 20);
    finish_frame("wrap");

    for (int t = 0; t < 20; t++) begin
      int nb;
      nb = $urandom_range(0, 24);
      random_src(nb);
      start_frame(32'h0000_0100 + 32'($urandom_range(0, 16)), 32'h0000_5000 + 32'(t * 256), nb);
      finish_frame("random");
    end

    // start while busy is ignored
    random_src(12);
    src[0] = 8'd9;
    start_frame(32'h0000_0100, 32'h0000_6000, 12);
    tick(4);
    rle_addr = 32'h0000_0180;
    rle_size = 32'd40;
    message_addr = 32'h0000_6800;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    finish_frame("busy_start");

    // reset during expansion
    src = '{8'hFF, 8'h77};
    start_frame(32'h0000_0100, 32'h0000_7000, 2);
    tick(40);
    for (int i = 0; i < 100 && state != EXPAND; i++) tick(1);
    check("mid_state_expand", 64'(state), 64'(EXPAND));
    #2 nreset = 1'b0;
    #1;
    check("mid_reset_size", 64'(message_size), 64'd0);
    check("mid_reset_done", 64'(done), 64'd0);
    check("mid_reset_we", 64'(mem_if.port_A_we), 64'd0);
    check("mid_reset_addr", 64'(mem_if.port_A_addr), 64'd0);
    check("mid_reset_wdata", 64'(mem_if.port_A_data_in), 64'd0);
    check("mid_reset_state", 64'(state), 64'(IDLE));
    exp_q.delete();
    exp_done_q.delete();
    tick(2);
    nreset = 1'b1;
    tick(30);
    src = '{8'h05, 8'h3C, 8'h01, 8'hC3};
    start_frame(32'h0000_0100, 32'h0000_7800, 4);
    finish_frame("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
